// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the sequential ALU.
//   op_e    : 4-bit opcode encoding
//   FLG_*   : bit positions inside the 4-bit flags word {dz, ovf, carry, zero}
//   state_e : control FSM states
//   is_div_op(): true for the opcodes that use the iterative divider
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_NOTA = 4'd5,
    OP_NOTB = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOR  = 4'd8,
    OP_XNOR = 4'd9,
    OP_SHL  = 4'd10,
    OP_AND  = 4'd11,
    OP_OR   = 4'd12,
    OP_INC  = 4'd13,
    OP_DEC  = 4'd14,
    OP_NAND = 4'd15
  } op_e;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_DZ    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle for seq_alu.
//   in_valid/in_ready   : request channel carrying a, b, op
//   out_valid/out_ready : response channel carrying y, flags {dz, ovf, carry, zero}
//   master modport : producer of operands / consumer of results
//   slave  modport : the ALU itself
interface seq_alu_if #(
  parameter int WIDTH = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  alu_pkg::op_e      op;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  y;
  logic [3:0]        flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, flags
  );

endinterface

// File: rtl/alu_divider.sv
// alu_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   i_start       : load operands and begin WIDTH iterations
//   i_dividend    : dividend (sampled on i_start)
//   i_divisor     : divisor  (sampled on i_start, must be non-zero)
//   o_done        : high during the cycle of the final iteration
//   o_quotient    : final quotient, valid while o_done is high
//   o_remainder   : final remainder, valid while o_done is high
// The results are presented combinationally alongside o_done so the caller
// can register them on the same edge that retires the last iteration.
module alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_quot;     // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_quot_next;
  logic [WIDTH-1:0] w_rem_next;

  assign w_shifted   = {r_rem, r_quot[WIDTH-1]};
  assign w_trial     = w_shifted - {1'b0, r_divisor};
  // A wrap-around of the trial subtraction sets the top bit: divisor did not fit.
  assign w_fits      = ~w_trial[WIDTH];
  assign w_rem_next  = w_fits ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign w_quot_next = {r_quot[WIDTH-2:0], w_fits};

  assign o_done      = r_busy && (r_cnt == CW'(1));
  assign o_quotient  = w_quot_next;
  assign o_remainder = w_rem_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (i_start) begin
      r_cnt     <= CW'(WIDTH);
      r_busy    <= 1'b1;
      r_quot    <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
    end else if (r_busy) begin
      r_quot <= w_quot_next;
      r_rem  <= w_rem_next;
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result and status flags.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_alu_if slave
//              in_valid/in_ready + a, b, op  -> request
//              out_valid/out_ready + y, flags -> response, flags = {dz, ovf, carry, zero}
// Every op except DIV/MOD with b != 0 completes in the accept cycle; those two
// hand off to alu_divider and return WIDTH cycles later.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus
);

  localparam int MSB = WIDTH - 1;

  state_e           r_state;
  logic [WIDTH-1:0] r_y;
  logic [3:0]       r_flags;
  logic             r_is_mod;

  // handshake decode
  logic w_accept;
  logic w_start_div;
  logic w_load_now;

  assign bus.in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.out_ready);
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.y         = r_y;
  assign bus.flags     = r_flags;

  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_start_div = w_accept && is_div_op(bus.op) && (bus.b != '0);
  // everything else, including divide-by-zero, resolves in the accept cycle
  assign w_load_now  = w_accept && !w_start_div;

  // single-cycle datapath
  logic [WIDTH-1:0]   w_one;
  logic [WIDTH-1:0]   w_opnd;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic               w_add_ovf;
  logic               w_sub_ovf;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH-1:0]   w_y;
  logic [3:0]         w_flags;
  logic               w_carry;
  logic               w_ovf;
  logic               w_dz;

  assign w_one     = {{(WIDTH-1){1'b0}}, 1'b1};
  // INC/DEC reuse the add/sub paths with a constant second operand
  assign w_opnd    = ((bus.op == OP_INC) || (bus.op == OP_DEC)) ? w_one : bus.b;
  assign w_add     = {1'b0, bus.a} + {1'b0, w_opnd};
  assign w_sub     = {1'b0, bus.a} - {1'b0, w_opnd};
  assign w_add_ovf = (bus.a[MSB] == w_opnd[MSB]) && (w_add[MSB] != bus.a[MSB]);
  assign w_sub_ovf = (bus.a[MSB] != w_opnd[MSB]) && (w_sub[MSB] != bus.a[MSB]);
  assign w_prod    = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
  // One guard bit above the result catches the last bit shifted out; large
  // shift amounts push everything past it, giving y=0 and carry=0.
  assign w_shl     = {1'b0, bus.a} << bus.b;

  always_comb begin
    w_y     = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_dz    = 1'b0;
    unique case (bus.op)
      OP_ADD, OP_INC: begin
        w_y     = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = w_add_ovf;
      end
      OP_SUB, OP_DEC: begin
        w_y     = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = w_sub_ovf;
      end
      OP_MUL: begin
        w_y     = w_prod[WIDTH-1:0];
        w_carry = |w_prod[2*WIDTH-1:WIDTH];
      end
      // only reaches the output registers when b == 0
      OP_DIV: begin
        w_y  = '1;
        w_dz = 1'b1;
      end
      OP_MOD: begin
        w_y  = bus.a;
        w_dz = 1'b1;
      end
      OP_NOTA: w_y = ~bus.a;
      OP_NOTB: w_y = ~bus.b;
      OP_XOR:  w_y = bus.a ^ bus.b;
      OP_NOR:  w_y = ~(bus.a | bus.b);
      OP_XNOR: w_y = ~(bus.a ^ bus.b);
      OP_SHL: begin
        w_y     = w_shl[WIDTH-1:0];
        w_carry = w_shl[WIDTH];
      end
      OP_AND:  w_y = bus.a & bus.b;
      OP_OR:   w_y = bus.a | bus.b;
      OP_NAND: w_y = ~(bus.a & bus.b);
      default: w_y = '0;
    endcase
    w_flags            = '0;
    w_flags[FLG_ZERO]  = (w_y == '0);
    w_flags[FLG_CARRY] = w_carry;
    w_flags[FLG_OVF]   = w_ovf;
    w_flags[FLG_DZ]    = w_dz;
  end

  // divider
  logic             w_div_done;
  logic [WIDTH-1:0] w_div_quot;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_y;
  logic [3:0]       w_div_flags;

  alu_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start_div),
    .i_dividend  (bus.a),
    .i_divisor   (bus.b),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quot),
    .o_remainder (w_div_rem)
  );

  always_comb begin
    w_div_y               = r_is_mod ? w_div_rem : w_div_quot;
    w_div_flags           = '0;
    w_div_flags[FLG_ZERO] = (w_div_y == '0);
  end

  // control FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_y      <= '0;
      r_flags  <= '0;
      r_is_mod <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_start_div) begin
            r_state  <= ST_BUSY;
            r_is_mod <= (bus.op == OP_MOD);
          end else if (w_load_now) begin
            r_state <= ST_HOLD;
            r_y     <= w_y;
            r_flags <= w_flags;
          end else if ((r_state == ST_HOLD) && bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (w_div_done) begin
            r_state <= ST_HOLD;
            r_y     <= w_div_y;
            r_flags <= w_div_flags;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
